// File: rtl/interval_meter_pkg.sv
// Shared types and constants for the interval meter and its future status register.
package interval_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Bit positions of the result flags in a status word.
    localparam int unsigned STAT_OVERFLOW_BIT  = 0;
    localparam int unsigned STAT_TIMED_OUT_BIT = 1;
    localparam int unsigned STAT_WIDTH         = 2;

endpackage

// File: rtl/interval_meter_sat_counter.sv
// Saturating up-counter: load sets it to 1, inc adds 1 until all-ones, sat is sticky.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] count_inc;

    assign count_inc = (count == MAX_COUNT) ? count : count + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (load) begin
            count <= ONE;
            sat   <= (ONE == MAX_COUNT);
        end else if (inc) begin
            count <= count_inc;
            sat   <= sat | (count_inc == MAX_COUNT);
        end
    end

endmodule

// File: rtl/interval_meter.sv
// Measures start-to-stop interval in cycles and returns it over a valid/ready handshake.
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter longint unsigned  TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             start_evt,
    input  logic             stop_evt,
    input  logic             abort,
    output logic [WIDTH-1:0] measured,
    output logic             overflow,
    output logic             timed_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);

    localparam logic [63:0]      MAX64      = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] TIMEOUT_W  = WIDTH'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("interval_meter: WIDTH must be in 1..32");
        end
        if (64'(TIMEOUT) > MAX64) begin : g_bad_timeout
            $error("interval_meter: TIMEOUT does not fit in WIDTH bits");
        end
    endgenerate

    state_e           state, state_d;
    logic [WIDTH-1:0] measured_d;
    logic             overflow_d, timed_out_d, valid_d;
    logic             cnt_load, cnt_inc, cnt_clr, cnt_sat;
    logic [WIDTH-1:0] cnt_count;

    // Abort wipes the counter along with the FSM.
    assign cnt_clr = rst | abort;

    sat_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (cnt_clr),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (cnt_count),
        .sat   (cnt_sat)
    );

    always_comb begin
        state_d     = state;
        measured_d  = measured;
        overflow_d  = overflow;
        timed_out_d = timed_out;
        valid_d     = valid;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            overflow_d  = 1'b0;
            timed_out_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) state_d = ARMED;
                end
                ARMED: begin
                    if (start_evt) begin
                        state_d  = COUNT;
                        cnt_load = 1'b1;
                    end
                end
                COUNT: begin
                    cnt_inc = 1'b1;
                    // Stop takes precedence over a coincident timeout.
                    if (stop_evt) begin
                        state_d     = HOLD;
                        measured_d  = cnt_count;
                        overflow_d  = cnt_sat;
                        timed_out_d = 1'b0;
                        valid_d     = 1'b1;
                    end else if (TIMEOUT_EN && cnt_count == TIMEOUT_W) begin
                        state_d     = HOLD;
                        measured_d  = TIMEOUT_W;
                        overflow_d  = cnt_sat;
                        timed_out_d = 1'b1;
                        valid_d     = 1'b1;
                    end
                end
                HOLD: begin
                    if (valid && ready) begin
                        state_d     = IDLE;
                        valid_d     = 1'b0;
                        overflow_d  = 1'b0;
                        timed_out_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            measured  <= '0;
            overflow  <= 1'b0;
            timed_out <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            measured  <= measured_d;
            overflow  <= overflow_d;
            timed_out <= timed_out_d;
            valid     <= valid_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: three configurations driven in parallel against an event-level model.
module tb_interval_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, arm = 1'b0, start_evt = 1'b0, stop_evt = 1'b0;
    logic abort = 1'b0, ready = 1'b0;

    logic [31:0] m0;
    logic [3:0]  m1;
    logic [31:0] m2;
    logic ov [3];
    logic to [3];
    logic vl [3];
    logic bz [3];

    interval_meter #(.WIDTH(32), .TIMEOUT(0)) u0 (
        .clk(clk), .rst(rst), .arm(arm), .start_evt(start_evt), .stop_evt(stop_evt),
        .abort(abort), .measured(m0), .overflow(ov[0]), .timed_out(to[0]),
        .valid(vl[0]), .ready(ready), .busy(bz[0]));

    interval_meter #(.WIDTH(4), .TIMEOUT(0)) u1 (
        .clk(clk), .rst(rst), .arm(arm), .start_evt(start_evt), .stop_evt(stop_evt),
        .abort(abort), .measured(m1), .overflow(ov[1]), .timed_out(to[1]),
        .valid(vl[1]), .ready(ready), .busy(bz[1]));

    interval_meter #(.WIDTH(32), .TIMEOUT(8)) u2 (
        .clk(clk), .rst(rst), .arm(arm), .start_evt(start_evt), .stop_evt(stop_evt),
        .abort(abort), .measured(m2), .overflow(ov[2]), .timed_out(to[2]),
        .valid(vl[2]), .ready(ready), .busy(bz[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: per instance, a phase (0 idle, 1 armed, 2 measuring, 3 result held),
    // the edge index of the start event, and the expected result fields.
    longint mx  [3] = '{64'hFFFF_FFFF, 15, 64'hFFFF_FFFF};
    longint tmo [3] = '{0, 0, 8};
    int     phase [3];
    longint t_start [3];
    longint e_meas [3];
    bit     e_ovf [3], e_to [3], e_val [3], meas_known [3];
    longint edge_n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            longint k;
            if (rst) begin
                phase[i] = 0; e_meas[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
                e_val[i] = 0; meas_known[i] = 1;
            end else if (abort) begin
                phase[i] = 0; e_ovf[i] = 0; e_to[i] = 0; e_val[i] = 0; meas_known[i] = 0;
            end else begin
                case (phase[i])
                    0: if (arm) phase[i] = 1;
                    1: if (start_evt) begin phase[i] = 2; t_start[i] = edge_n; end
                    2: begin
                        k = edge_n - t_start[i];
                        if (stop_evt) begin
                            phase[i] = 3; e_val[i] = 1; meas_known[i] = 1;
                            e_meas[i] = (k < mx[i]) ? k : mx[i];
                            e_ovf[i] = (k >= mx[i]); e_to[i] = 0;
                        end else if (tmo[i] != 0 && k == tmo[i]) begin
                            phase[i] = 3; e_val[i] = 1; meas_known[i] = 1;
                            e_meas[i] = tmo[i]; e_ovf[i] = (k >= mx[i]); e_to[i] = 1;
                        end
                    end
                    default: if (ready) begin
                        phase[i] = 0; e_val[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
                        meas_known[i] = 0;
                    end
                endcase
            end
        end
        edge_n++;
    endtask

    task automatic check_inst(input int i, input logic [63:0] m);
        check($sformatf("u%0d.valid", i), 64'(vl[i]), 64'(e_val[i]));
        check($sformatf("u%0d.busy", i), 64'(bz[i]), 64'(phase[i] != 0));
        check($sformatf("u%0d.overflow", i), 64'(ov[i]), 64'(e_ovf[i]));
        check($sformatf("u%0d.timed_out", i), 64'(to[i]), 64'(e_to[i]));
        if (meas_known[i]) check($sformatf("u%0d.measured", i), m, 64'(e_meas[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_inst(0, 64'(m0));
        check_inst(1, 64'(m1));
        check_inst(2, 64'(m2));
    endtask

    task automatic cyc(input logic a, input logic s, input logic p,
                       input logic ab, input logic rd, input logic r);
        arm = a; start_evt = s; stop_evt = p; abort = ab; ready = rd; rst = r;
        step();
    endtask

    task automatic idle(input int n, input logic rd);
        for (int j = 0; j < n; j++) cyc(0, 0, 0, 0, rd, 0);
    endtask

    initial begin
        // Reset state
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Basic interval: stop five edges after start
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        idle(4, 1);
        arm = 0; start_evt = 0; stop_evt = 1; abort = 0; ready = 0; rst = 0;
        step();
        check("t1.measured", 64'(m0), 64'd5);
        check("t1.valid", 64'(vl[0]), 64'd1);
        cyc(0, 0, 0, 0, 1, 0);
        check("t1.busy_after_accept", 64'(bz[0]), 64'd0);

        // Same-cycle start and stop: the stop is ignored
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        check("t2.no_valid", 64'(vl[0]), 64'd0);
        idle(2, 1);
        cyc(0, 0, 1, 0, 0, 0);
        check("t2.measured", 64'(m0), 64'd3);
        cyc(0, 0, 0, 0, 1, 0);

        // Saturation on the 4-bit instance, interval 20
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(19, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("t3.measured", 64'(m1), 64'd15);
        check("t3.overflow", 64'(ov[1]), 64'd1);
        check("t3.timeout_u2", 64'(to[2]), 64'd1);
        cyc(0, 0, 0, 0, 1, 0);

        // Timeout without stop, then stop exactly on the timeout cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(10, 0);
        check("t4a.measured", 64'(m2), 64'd8);
        check("t4a.timed_out", 64'(to[2]), 64'd1);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2, 1);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        idle(7, 1);
        cyc(0, 0, 1, 0, 0, 0);
        check("t4b.measured", 64'(m2), 64'd8);
        check("t4b.timed_out", 64'(to[2]), 64'd0);
        cyc(0, 0, 0, 0, 1, 0);

        // Backpressure with stray pulses, accept with a coincident arm
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("t5.measured_stable", 64'(m0), 64'd3);
        cyc(1, 0, 0, 0, 1, 0);
        check("t5.idle_after_accept", 64'(bz[0]), 64'd0);
        cyc(0, 1, 0, 0, 0, 0);
        check("t5.arm_ignored", 64'(bz[0]), 64'd0);

        // Abort and reset at count 6, then a fresh measurement
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(5, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("t6.abort_busy", 64'(bz[0]), 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(5, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("t6.rst_measured", 64'(m0), 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("t6.fresh_measured", 64'(m0), 64'd4);
        cyc(0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 999));
            cyc(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
                logic'($urandom_range(0, 11) == 0), logic'(r >= 3 && r < 12),
                logic'($urandom_range(0, 2) != 0), logic'(r < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
